// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two
// valid/ready requesters; operands, op and result are registered.
module alu_share_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [2:0]        req_op_0,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_b_0,
  output logic              resp_valid_0,
  input  logic              resp_ready_0,
  output logic [DATA_W-1:0] resp_data_0,
  output logic              resp_zero_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [2:0]        req_op_1,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_1,
  output logic              resp_valid_1,
  input  logic              resp_ready_1,
  output logic [DATA_W-1:0] resp_data_1,
  output logic              resp_zero_1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
);

  localparam int unsigned CNT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [2:0]  OP_MUL = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                zero_q, zero_d;

  logic                grant_0, grant_1;
  logic [2:0]          sel_op;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic                owner_ready;

  // Grant: a lone valid wins; on contention rr_ptr picks the winner.
  always_comb begin
    grant_0 = req_valid_0 & (~req_valid_1 | ~rr_ptr_q);
    grant_1 = req_valid_1 & (~req_valid_0 |  rr_ptr_q);
    sel_op  = grant_1 ? req_op_1 : req_op_0;
    sel_a   = grant_1 ? req_a_1  : req_a_0;
    sel_b   = grant_1 ? req_b_1  : req_b_0;
    owner_ready = owner_q ? resp_ready_1 : resp_ready_0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    zero_d   = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_0 | grant_1) begin
          owner_d = grant_1;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          cnt_d   = (sel_op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          res_d   = alu_out;
          zero_d  = alu_zero;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // Result is held for as long as the owner applies backpressure.
        if (owner_ready) begin
          rr_ptr_d = ~owner_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_0  = ~rst & (state_q == S_IDLE) & grant_0;
  assign req_ready_1  = ~rst & (state_q == S_IDLE) & grant_1;
  assign resp_valid_0 = (state_q == S_RESP) & ~owner_q;
  assign resp_valid_1 = (state_q == S_RESP) &  owner_q;
  assign resp_data_0  = res_q;
  assign resp_data_1  = res_q;
  assign resp_zero_0  = zero_q;
  assign resp_zero_1  = zero_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;

endmodule
